// File: rtl/lnic_homa_egress_prio.sv
// Homa egress priority tagger: looks up a per-message priority over a register
// port, then stamps it into the IPv4 TOS byte of the packet head beat.
module lnic_homa_egress_prio #(
    parameter int TDATA_W       = 512,
    parameter int NUM_PRIO      = 8,
    parameter int PRIO_BYTE_OFF = 15,
    parameter int RESP_TIMEOUT  = 64,
    parameter int DEFAULT_PRIO  = 7
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 net_meta_in_valid,
    output logic                 net_meta_in_ready,
    input  logic [15:0]          net_meta_in_bits_tx_msg_id,
    input  logic [7:0]           net_meta_in_bits_rank,
    input  logic                 net_meta_in_bits_is_new_msg,
    input  logic                 net_meta_in_bits_is_rtx,

    input  logic                 net_net_in_valid,
    output logic                 net_net_in_ready,
    input  logic [TDATA_W-1:0]   net_net_in_bits_data,
    input  logic [TDATA_W/8-1:0] net_net_in_bits_keep,
    input  logic                 net_net_in_bits_last,

    output logic                 net_net_out_valid,
    input  logic                 net_net_out_ready,
    output logic [TDATA_W-1:0]   net_net_out_bits_data,
    output logic [TDATA_W/8-1:0] net_net_out_bits_keep,
    output logic                 net_net_out_bits_last,

    output logic                 net_txMsgPrioReg_req_valid,
    output logic [15:0]          net_txMsgPrioReg_req_bits_index,
    output logic                 net_txMsgPrioReg_req_bits_update,
    output logic [7:0]           net_txMsgPrioReg_req_bits_prio,
    input  logic                 net_txMsgPrioReg_resp_valid,
    input  logic [7:0]           net_txMsgPrioReg_resp_bits_prio,

    output logic [31:0]          pkt_count,
    output logic [15:0]          timeout_count
);
    localparam logic [7:0] PMAX = 8'(NUM_PRIO - 1);
    localparam int TW = (RESP_TIMEOUT > 2) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HEAD, BODY} state_t;

    state_t        state_q, state_d;
    logic [15:0]   id_q, id_d;
    logic [7:0]    rank_q, rank_d;
    logic          new_q, new_d;
    logic          rtx_q, rtx_d;
    logic [7:0]    prio_q, prio_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   pkt_q, pkt_d;
    logic [15:0]   tmo_q, tmo_d;
    logic          pass, fire;

    function automatic logic [7:0] clamp(input logic [7:0] p);
        return (p > PMAX) ? PMAX : p;
    endfunction

    assign pass = (state_q == HEAD) || (state_q == BODY);
    assign fire = pass && net_net_in_valid && net_net_out_ready;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        rank_d  = rank_q;
        new_d   = new_q;
        rtx_d   = rtx_q;
        prio_d  = prio_q;
        timer_d = timer_q;
        pkt_d   = pkt_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: if (net_meta_in_valid) begin
                id_d    = net_meta_in_bits_tx_msg_id;
                rank_d  = net_meta_in_bits_rank;
                new_d   = net_meta_in_bits_is_new_msg;
                rtx_d   = net_meta_in_bits_is_rtx;
                state_d = REQ;
            end
            REQ: begin
                timer_d = '0;
                state_d = WAIT;
            end
            // A response arriving on the expiry cycle takes precedence over the timeout.
            WAIT: if (net_txMsgPrioReg_resp_valid) begin
                prio_d  = rtx_q ? 8'd0 : clamp(net_txMsgPrioReg_resp_bits_prio);
                state_d = HEAD;
            end else if (timer_q == TLAST) begin
                prio_d  = rtx_q ? 8'd0 : 8'(DEFAULT_PRIO);
                if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
                state_d = HEAD;
            end else begin
                timer_d = timer_q + TW'(1);
            end
            HEAD: if (fire) begin
                state_d = net_net_in_bits_last ? IDLE : BODY;
                if (net_net_in_bits_last) pkt_d = pkt_q + 32'd1;
            end
            BODY: if (fire && net_net_in_bits_last) begin
                state_d = IDLE;
                pkt_d   = pkt_q + 32'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= '0;
            rank_q  <= '0;
            new_q   <= 1'b0;
            rtx_q   <= 1'b0;
            prio_q  <= '0;
            timer_q <= '0;
            pkt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            rank_q  <= rank_d;
            new_q   <= new_d;
            rtx_q   <= rtx_d;
            prio_q  <= prio_d;
            timer_q <= timer_d;
            pkt_q   <= pkt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign net_meta_in_ready                = (state_q == IDLE);
    assign net_txMsgPrioReg_req_valid       = (state_q == REQ);
    assign net_txMsgPrioReg_req_bits_index  = (state_q == REQ) ? id_q : 16'd0;
    assign net_txMsgPrioReg_req_bits_update = (state_q == REQ) && new_q;
    assign net_txMsgPrioReg_req_bits_prio   = (state_q == REQ) ? clamp(rank_q) : 8'd0;

    assign net_net_out_valid     = pass && net_net_in_valid;
    assign net_net_in_ready      = pass && net_net_out_ready;
    assign net_net_out_bits_keep = net_net_in_bits_keep;
    assign net_net_out_bits_last = net_net_in_bits_last;

    always_comb begin
        net_net_out_bits_data = net_net_in_bits_data;
        if (state_q == HEAD)
            net_net_out_bits_data[8*PRIO_BYTE_OFF +: 8] =
                {prio_q[2:0], net_net_in_bits_data[8*PRIO_BYTE_OFF +: 5]};
    end

    assign pkt_count     = pkt_q;
    assign timeout_count = tmo_q;
endmodule

// File: tb/tb_lnic_homa_egress_prio.sv
// Directed bench: table of packets with hand-computed priority/TOS results,
// plus hand sequences for backpressure, stray responses and mid-packet reset.
module tb_lnic_homa_egress_prio;
    localparam int TDATA_W = 512;
    localparam int KW      = TDATA_W / 8;
    localparam int RTO     = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic               meta_valid = 0, meta_ready;
    logic [15:0]        meta_id = 0;
    logic [7:0]         meta_rank = 0;
    logic               meta_new = 0, meta_rtx = 0;
    logic               in_valid = 0, in_ready, in_last = 0;
    logic [TDATA_W-1:0] in_data = '0;
    logic [KW-1:0]      in_keep = '0;
    logic               out_valid, out_ready = 0, out_last;
    logic [TDATA_W-1:0] out_data;
    logic [KW-1:0]      out_keep;
    logic               req_valid, req_update;
    logic [15:0]        req_index;
    logic [7:0]         req_prio;
    logic               resp_valid = 0;
    logic [7:0]         resp_prio = 0;
    logic [31:0]        pkt_count;
    logic [15:0]        timeout_count;

    lnic_homa_egress_prio dut (
        .clock(clock), .reset(reset),
        .net_meta_in_valid(meta_valid), .net_meta_in_ready(meta_ready),
        .net_meta_in_bits_tx_msg_id(meta_id), .net_meta_in_bits_rank(meta_rank),
        .net_meta_in_bits_is_new_msg(meta_new), .net_meta_in_bits_is_rtx(meta_rtx),
        .net_net_in_valid(in_valid), .net_net_in_ready(in_ready),
        .net_net_in_bits_data(in_data), .net_net_in_bits_keep(in_keep),
        .net_net_in_bits_last(in_last),
        .net_net_out_valid(out_valid), .net_net_out_ready(out_ready),
        .net_net_out_bits_data(out_data), .net_net_out_bits_keep(out_keep),
        .net_net_out_bits_last(out_last),
        .net_txMsgPrioReg_req_valid(req_valid), .net_txMsgPrioReg_req_bits_index(req_index),
        .net_txMsgPrioReg_req_bits_update(req_update), .net_txMsgPrioReg_req_bits_prio(req_prio),
        .net_txMsgPrioReg_resp_valid(resp_valid), .net_txMsgPrioReg_resp_bits_prio(resp_prio),
        .pkt_count(pkt_count), .timeout_count(timeout_count)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [TDATA_W-1:0] act, input logic [TDATA_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // resp_dly: cycles after the req cycle that the response is driven (-1 = none)
    typedef struct {
        logic [15:0] id;
        logic [7:0]  rank;
        logic        is_new;
        logic        rtx;
        int          resp_dly;
        logic [7:0]  rp;
        logic [7:0]  hb;
        int          nbeats;
        int          stall_beat;
        logic [7:0]  exp_req_prio;
        logic [7:0]  exp_byte;
        logic [15:0] exp_tmo;
    } vec_t;

    function automatic logic [TDATA_W-1:0] beat_data(input int b, input logic [15:0] id);
        logic [TDATA_W-1:0] d;
        for (int k = 0; k < KW; k++) d[8*k +: 8] = 8'(k * 7 + b * 31 + int'(id));
        return d;
    endfunction

    logic [31:0] exp_pkt = 0;

    task automatic run_pkt(input vec_t v);
        int hc;
        logic [TDATA_W-1:0] d, e;
        hc = (v.resp_dly >= 0) ? v.resp_dly + 1 : RTO + 1;
        meta_valid = 1; meta_id = v.id; meta_rank = v.rank; meta_new = v.is_new; meta_rtx = v.rtx;
        #1 chk("meta_ready_idle", 512'(meta_ready), 512'(1));
        step();
        meta_valid = 0;
        chk("req_valid", 512'(req_valid), 512'(1));
        chk("req_index", 512'(req_index), 512'(v.id));
        chk("req_update", 512'(req_update), 512'(v.is_new));
        chk("req_prio", 512'(req_prio), 512'(v.exp_req_prio));
        d = beat_data(0, v.id);
        d[8*15 +: 8] = v.hb;
        for (int i = 1; i < hc; i++) begin
            step();
            resp_valid = (i == v.resp_dly);
            resp_prio  = v.rp;
            in_valid = 1; in_data = d; in_keep = '1; in_last = (v.nbeats == 1); out_ready = 1;
            #1;
            if (i == 1) chk("req_one_cycle", 512'({req_valid, req_index, req_prio}), 512'(0));
            if (i == hc - 1) chk("wait_stalled", 512'({in_ready, out_valid}), 512'(0));
        end
        step();
        resp_valid = 0;
        for (int b = 0; b < v.nbeats; b++) begin
            d = beat_data(b, v.id);
            if (b == 0) d[8*15 +: 8] = v.hb;
            e = d;
            if (b == 0) e[8*15 +: 8] = v.exp_byte;
            in_valid = 1; in_data = d; in_last = (b == v.nbeats - 1);
            in_keep = in_last ? KW'(64'h0000_00FF_FF0F_F0F1) : '1;
            if (b == v.stall_beat) begin
                for (int s = 0; s < 10; s++) begin
                    out_ready = 0;
                    #1;
                    chk("stall_in_ready", 512'(in_ready), 512'(0));
                    chk("stall_data", out_data, e);
                    step();
                end
            end
            out_ready = 1;
            #1;
            chk("out_valid", 512'(out_valid), 512'(1));
            chk("out_data", out_data, e);
            chk("out_keep_last", 512'({out_keep, out_last}), 512'({in_keep, in_last}));
            step();
        end
        in_valid = 0; in_last = 0;
        exp_pkt++;
        #1;
        chk("meta_ready_after", 512'(meta_ready), 512'(1));
        chk("pkt_count", 512'(pkt_count), 512'(exp_pkt));
        chk("timeout_count", 512'(timeout_count), 512'(v.exp_tmo));
    endtask

    vec_t tbl[8];

    initial begin
        //          id        rank   new  rtx  dly  rp     hb     nb stl reqp  byte   tmo
        tbl[0] = '{16'h0005, 8'd3,  1'b1, 1'b0, 2,  8'd3,  8'h00, 2, -1, 8'd3, 8'h60, 16'd0};
        tbl[1] = '{16'h1234, 8'd12, 1'b0, 1'b0, 2,  8'd12, 8'h1F, 3, -1, 8'd7, 8'hFF, 16'd0};
        tbl[2] = '{16'h0009, 8'd2,  1'b1, 1'b0, -1, 8'd0,  8'h05, 1, -1, 8'd2, 8'hE5, 16'd1};
        tbl[3] = '{16'h000A, 8'd1,  1'b0, 1'b0, 3,  8'd2,  8'h0A, 2, -1, 8'd1, 8'h4A, 16'd1};
        tbl[4] = '{16'h000B, 8'd5,  1'b0, 1'b1, 2,  8'd5,  8'hFF, 1, -1, 8'd5, 8'h1F, 16'd1};
        tbl[5] = '{16'h000C, 8'd0,  1'b0, 1'b1, -1, 8'd0,  8'hE3, 1, -1, 8'd0, 8'h03, 16'd2};
        tbl[6] = '{16'h000D, 8'd4,  1'b1, 1'b0, RTO, 8'd1, 8'h00, 1, -1, 8'd4, 8'h20, 16'd2};
        tbl[7] = '{16'h000E, 8'd7,  1'b0, 1'b0, 1,  8'd4,  8'h11, 4, 2,  8'd7, 8'h91, 16'd2};

        step(); step();
        reset = 0;
        #1;
        chk("rst_meta_ready", 512'(meta_ready), 512'(1));
        chk("rst_valids", 512'({out_valid, req_valid, in_ready}), 512'(0));
        chk("rst_counts", 512'({pkt_count, timeout_count}), 512'(0));

        for (int i = 0; i < 8; i++) run_pkt(tbl[i]);

        // Stray responses in IDLE must neither move the FSM nor leave a priority behind.
        resp_valid = 1; resp_prio = 8'd2;
        step(); step();
        resp_valid = 0;
        chk("idle_resp_state", 512'(meta_ready), 512'(1));
        chk("idle_resp_counts", 512'({pkt_count, timeout_count}), 512'({exp_pkt, 16'd2}));
        run_pkt('{16'h0020, 8'd1, 1'b0, 1'b0, -1, 8'd0, 8'h00, 1, -1, 8'd1, 8'hE0, 16'd3});

        // Reset while a packet is in BODY.
        meta_valid = 1; meta_id = 16'h0030; meta_rank = 8'd2; meta_new = 0; meta_rtx = 0;
        step(); meta_valid = 0;
        step(); resp_valid = 1; resp_prio = 8'd2;
        step(); resp_valid = 0;
        in_valid = 1; in_data = beat_data(0, 16'h30); in_keep = '1; in_last = 0; out_ready = 1;
        #1 chk("pre_rst_head", 512'(out_valid), 512'(1));
        step();
        #1 chk("pre_rst_body", 512'(out_valid), 512'(1));
        reset = 1;
        step();
        reset = 0;
        #1;
        chk("rst_body_out_valid", 512'({out_valid, in_ready}), 512'(0));
        chk("rst_body_counts", 512'({pkt_count, timeout_count}), 512'(0));
        chk("rst_body_meta_ready", 512'(meta_ready), 512'(1));
        step();
        chk("rst_body_stalled", 512'({out_valid, in_ready}), 512'(0));
        in_valid = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
